// File: rtl/fx3_sample_packer.sv
// IF sample packer feeding the FX3 synchronous slave FIFO.
// Packs byte pairs into words, buffers them and commits short packets on stop.
module fx3_sample_packer #(
  parameter int FIFO_AW   = 4,
  parameter int BUF_WORDS = 8192,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             grst,
  input  logic             en,
  input  logic             tg_on,
  input  logic [7:0]       if_data,
  input  logic             flag_rdy,
  output logic [15:0]      dq,
  output logic             slcs_n,
  output logic             slwr_n,
  output logic             pktend_n,
  output logic             busy,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int PW    = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_PKTEND
  } state_t;

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic [7:0]         lo_q, lo_d;
  logic [15:0]        tg_q, tg_d;
  logic [PW-1:0]      pkt_q, pkt_d;
  logic [FIFO_AW:0]   wp_q, wp_d;
  logic [FIFO_AW:0]   rp_q, rp_d;
  logic [15:0]        dq_q, dq_d;
  logic               slwr_n_q, slwr_n_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        mem [DEPTH];

  logic               empty, full, active;
  logic               pop, push, acc;
  logic [15:0]        pword;

  always_comb begin
    empty  = (wp_q == rp_q);
    full   = ((wp_q ^ rp_q) == {1'b1, {FIFO_AW{1'b0}}});
    active = (state_q == S_RUN) || (state_q == S_FLUSH);
    pop    = active && !empty && flag_rdy;
    push   = (state_q == S_RUN) && en && phase_q;
    // A full FIFO still accepts a word when the head leaves this cycle
    acc    = push && (!full || pop);
    pword  = tg_on ? tg_q : {if_data, lo_q};
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    lo_d     = lo_q;
    tg_d     = tg_q;
    pkt_d    = pkt_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    dq_d     = dq_q;
    slwr_n_d = !pop;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;

    if (pop) begin
      dq_d  = mem[rp_q[FIFO_AW-1:0]];
      rp_d  = rp_q + 1'b1;
      pkt_d = (pkt_q == PW'(BUF_WORDS - 1)) ? '0 : pkt_q + 1'b1;
    end
    if (acc) begin
      wp_d = wp_q + 1'b1;
    end
    if (push && tg_on) begin
      tg_d = tg_q + 16'd1;
    end
    if (push && !acc) begin
      ovf_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_RUN;
          phase_d = 1'b0;
          pkt_d   = '0;
          tg_d    = '0;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_FLUSH;
          phase_d = 1'b0;
        end else begin
          phase_d = !phase_q;
          if (!phase_q) begin
            lo_d = if_data;
          end
        end
      end
      S_FLUSH: begin
        if (empty && slwr_n_q) begin
          state_d = (pkt_q != '0) ? S_PKTEND : S_IDLE;
        end
      end
      S_PKTEND: begin
        pkt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (grst) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      lo_q     <= '0;
      tg_q     <= '0;
      pkt_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      dq_q     <= '0;
      slwr_n_q <= 1'b1;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      lo_q     <= lo_d;
      tg_q     <= tg_d;
      pkt_q    <= pkt_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      dq_q     <= dq_d;
      slwr_n_q <= slwr_n_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      mem[wp_q[FIFO_AW-1:0]] <= pword;
    end
  end

  assign dq       = dq_q;
  assign slwr_n   = slwr_n_q;
  assign slcs_n   = (state_q == S_IDLE);
  assign pktend_n = (state_q != S_PKTEND);
  assign busy     = (state_q != S_IDLE);
  assign ovf      = ovf_q;
  assign ovf_cnt  = cnt_q;

endmodule
